// File: rtl/pack_fifo.sv
// pack_fifo: width-packing FIFO.
// RATIO input beats of IN_W bits are packed LSB-first into one OUT_W word.
// Packed words are stored in a DEPTH-entry circular buffer and read out one per request.
// Optional build macro PACK_FIFO_FLUSH_EN adds a flush input that commits a partial word.
module pack_fifo #(
    parameter  int IN_W  = 4,
    parameter  int RATIO = 2,
    parameter  int DEPTH = 8,
    localparam int OUT_W = IN_W * RATIO,
    localparam int AW    = $clog2(DEPTH),
    localparam int BW    = (RATIO <= 2) ? 1 : $clog2(RATIO)
) (
    input  logic             clk,
    input  logic             rst,
`ifdef PACK_FIFO_FLUSH_EN
    input  logic             flush,
`endif
    input  logic [IN_W-1:0]  Data_In,
    input  logic             input_enable,
    output logic             input_valid,
    input  logic             output_enable,
    output logic [OUT_W-1:0] Data_Out,
    output logic             output_valid,
    output logic [AW:0]      count,
    output logic [BW-1:0]    beat_idx,
    output logic             full,
    output logic             empty
);

    localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);
    localparam logic [BW-1:0] LAST_BEAT = BW'(RATIO - 1);

    logic [OUT_W-1:0] ram_q [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [BW-1:0]    beat_q, beat_d;
    logic [OUT_W-1:0] pack_q, pack_d;
    logic [OUT_W-1:0] dout_q, dout_d;
    logic             ovalid_q, ovalid_d;

    logic             flush_req;
    logic             beat_acc;
    logic             beat_commit;
    logic             flush_commit;
    logic             commit;
    logic             rd_acc;
    logic [OUT_W-1:0] pack_ins;
    logic [OUT_W-1:0] commit_word;

`ifdef PACK_FIFO_FLUSH_EN
    assign flush_req = flush;
`else
    assign flush_req = 1'b0;
`endif

    assign full         = (count_q == FULL_CNT);
    assign empty        = (count_q == '0);
    // Only the completing beat is held off when full; a flush blocks all beats that cycle.
    assign input_valid  = !(full && (beat_q == LAST_BEAT)) && !flush_req;
    assign beat_acc     = input_enable && input_valid;
    assign beat_commit  = beat_acc && (beat_q == LAST_BEAT);
    assign flush_commit = flush_req && (beat_q != '0) && !full;
    assign commit       = beat_commit || flush_commit;
    assign rd_acc       = output_enable && !empty;

    assign Data_Out     = dout_q;
    assign output_valid = ovalid_q;
    assign count        = count_q;
    assign beat_idx     = beat_q;

    // Next-state computation for packing, pointers, occupancy and read port.
    always_comb begin
        pack_ins = pack_q;
        pack_ins[int'(beat_q)*IN_W +: IN_W] = Data_In;
        commit_word = flush_commit ? pack_q : pack_ins;

        pack_d   = pack_q;
        beat_d   = beat_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;
        ovalid_d = 1'b0;

        if (beat_acc) begin
            if (beat_q == LAST_BEAT) begin
                pack_d = '0;
                beat_d = '0;
            end else begin
                pack_d = pack_ins;
                beat_d = beat_q + 1'b1;
            end
        end else if (flush_commit) begin
            pack_d = '0;
            beat_d = '0;
        end

        if (commit) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            dout_d   = ram_q[rd_ptr_q];
            ovalid_d = 1'b1;
        end

        if (commit && !rd_acc) begin
            count_d = count_q + 1'b1;
        end else if (rd_acc && !commit) begin
            count_d = count_q - 1'b1;
        end
    end

    // Control and output registers, cleared immediately by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            beat_q   <= '0;
            pack_q   <= '0;
            dout_q   <= '0;
            ovalid_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            beat_q   <= beat_d;
            pack_q   <= pack_d;
            dout_q   <= dout_d;
            ovalid_q <= ovalid_d;
        end
    end

    // Word storage; contents survive reset and are only meaningful below count.
    always_ff @(posedge clk) begin
        if (commit) begin
            ram_q[wr_ptr_q] <= commit_word;
        end
    end

endmodule

// File: doc/pack_fifo.md
Name: pack_fifo

Overview:
Parametrised width-packing FIFO, the next generation of the nibble-to-byte fifo.
- Accepts narrow input beats of IN_W bits and packs RATIO consecutive beats LSB-first into one OUT_W = IN_W*RATIO word.
- Stores packed words in a DEPTH-entry circular buffer and returns one word per accepted read.
- Adds an occupancy count, explicit full/empty flags and a registered read pulse.

Parameters:
IN_W, 4, input beat width in bits (>=1)
RATIO, 2, input beats per stored word (>=2); OUT_W = IN_W*RATIO
DEPTH, 8, stored word entries; power of two, >=2; AW = log2(DEPTH)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
Data_In  in  IN_W  input beat
input_enable  in  1  producer offers Data_In this cycle
input_valid  out  1  beat will be accepted this cycle (ready); combinational
output_enable  in  1  consumer requests one word this cycle
Data_Out  out  OUT_W  last word read; registered
output_valid  out  1  one-cycle pulse: Data_Out updated by the previous edge
count  out  AW+1  stored complete words, 0..DEPTH
beat_idx  out  log2(RATIO) (min 1)  beats held in the packing register
full  out  1  count == DEPTH
empty  out  1  count == 0

Behaviour:
- Reset values (async, immediate while rst=1):
  - wr_ptr = rd_ptr = 0; count = 0; beat_idx = 0; pack register = 0.
  - Data_Out = 0; output_valid = 0; full = 0; empty = 1.
  - RAM contents are not reset.
- Reset mid-operation discards stored words and any partial word. No output pulse is produced on the first edge after release.
- input_valid = !(full && beat_idx == RATIO-1). While full, partial beats continue to be accepted; only the completing beat is blocked.
- Accepted beat (input_enable && input_valid at posedge): Data_In is written to pack slot beat_idx, at bits [beat_idx*IN_W +: IN_W].
  - If beat_idx < RATIO-1: beat_idx increments.
  - If beat_idx == RATIO-1: the completed word, including the current beat, is written to ram[wr_ptr]; wr_ptr increments mod DEPTH; beat_idx returns to 0; pack register clears.
- Read accepted when output_enable && !empty at posedge: Data_Out <= ram[rd_ptr]; rd_ptr increments mod DEPTH; output_valid = 1 for the following cycle.
- Read when empty: ignored. Data_Out holds, output_valid = 0, no pointer change.
- output_valid is 0 in every cycle that does not follow an accepted read. Back-to-back reads give consecutive pulses.
- Simultaneous word commit and read in the same cycle: both happen, and count is unchanged.
  - input_valid is evaluated from pre-edge state, so there is no bypass: a completing beat is blocked when full, even if a read happens in the same cycle.
  - When empty, a word committed this cycle is not readable until the next cycle.
- Write-to-read latency: a word committed at edge N is readable at edge N+1; Data_Out is visible after edge N+1.
- Pointer wrap is modulo DEPTH. Full and empty are derived from count, never from pointer equality alone.
- Word ordering is strict FIFO. Within a word, the first beat sits in the LSBs.

Optional Feature:
Macro PACK_FIFO_FLUSH_EN.
- Defined: adds input port flush (1 bit).
  - On posedge with flush=1 and beat_idx != 0 and !full: the partial word is committed with unfilled slots zero, and beat_idx returns to 0.
  - flush with beat_idx == 0 or full: no effect; the partial word is held.
  - While flush=1, input_valid is forced to 0, so no beat is accepted that cycle.
  - Reads proceed normally alongside a flush.
- Undefined: no flush port; partial words are only completed by further input beats.

Test Plan:
1. Reset, then beats 0x1,0x0 followed by one read -> Data_Out=0x01, output_valid pulses one cycle, count returns 0, empty=1.
2. Write 8 words (16 beats, each 0x3) -> full=1, count=8. Next beat is accepted (beat_idx=1). Completing beat is blocked (input_valid=0). One read returns 0x33; the completing beat is then accepted on the next cycle.
3. Read while empty -> Data_Out holds its previous value, output_valid=0, count stays 0.
4. With count=3, a completing beat and a read in the same cycle -> count stays 3. Data_Out is the oldest word. Pointers wrap correctly across 20 word cycles, with data order preserved.
5. Assert rst for one cycle while count=5 and beat_idx=1 -> all outputs reach reset values immediately. The first word after reset is built from new beats only.
6. (PACK_FIFO_FLUSH_EN) Beat 0xA, then flush -> count=1. Read gives 0x0A. A flush with beat_idx=0 changes nothing.
